// File: rtl/fnn_sched_pkg.sv
// Shared types and helpers for the layer input scheduler.
package fnn_sched_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_DONE = 2'd2
    } sched_state_t;

    // Width of an index that addresses n words; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/layer_hold_reg.sv
// Frame hold register: parallel load of all neuron outputs, single indexed read port.
module layer_hold_reg #(
    parameter int numNeurons = 30,
    parameter int dataWidth  = 16,
    parameter int idxWidth   = 5
) (
    input  logic                            i_clk,
    input  logic                            i_load,
    input  logic [numNeurons*dataWidth-1:0] i_data,
    input  logic [idxWidth-1:0]             i_rd_idx,
    output logic [dataWidth-1:0]            o_rd_data
);

    logic [dataWidth-1:0] r_mem [numNeurons];

    // Pure data storage; contents are only observable after a load.
    always_ff @(posedge i_clk) begin
        if (i_load) begin
            for (int k = 0; k < numNeurons; k++) begin
                r_mem[k] <= i_data[k*dataWidth +: dataWidth];
            end
        end
    end

    assign o_rd_data = r_mem[i_rd_idx];

endmodule

// File: rtl/layer_input_scheduler.sv
// Captures a full previous-layer frame and replays it serially to the next layer.
// Optional build macro LAYER_SCHED_ERR_CHECK_EN enables the sticky protocol error flag.
//
//   state     | meaning
//   IDLE      | waiting for all neurons to assert valid together
//   SEND      | streaming hold[0..numNeurons-1], one word per cycle
//   WAIT_DONE | stream finished, waiting for next layer's done pulse
module layer_input_scheduler
    import fnn_sched_pkg::*;
#(
    parameter int numNeurons = 30,
    parameter int dataWidth  = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [numNeurons*dataWidth-1:0] in_data,
    input  logic [numNeurons-1:0]           in_valid,
    input  logic                            next_done,
    output logic [dataWidth-1:0]            out_data,
    output logic                            out_valid,
    output logic                            busy,
    output logic                            err
);

    localparam int              IDX_W    = idx_width(numNeurons);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(numNeurons - 1);

    sched_state_t         r_state;
    sched_state_t         w_state_nxt;
    logic [IDX_W-1:0]     r_idx;
    logic [dataWidth-1:0] r_last;
    logic [dataWidth-1:0] w_rd_data;
    logic                 w_all_valid;
    logic                 w_load;

    assign w_all_valid = &in_valid;

    layer_hold_reg #(
        .numNeurons (numNeurons),
        .dataWidth  (dataWidth),
        .idxWidth   (IDX_W)
    ) u_hold (
        .i_clk     (clk),
        .i_load    (w_load),
        .i_data    (in_data),
        .i_rd_idx  (r_idx),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:      if (w_all_valid)       w_state_nxt = SEND;
            SEND:      if (r_idx == IDX_LAST) w_state_nxt = WAIT_DONE;
            WAIT_DONE: if (next_done)         w_state_nxt = IDLE;
            default:                          w_state_nxt = IDLE;
        endcase
    end

    // Output word reads the hold register directly so word 0 appears the cycle after capture.
    always_comb begin
        out_valid = 1'b0;
        out_data  = r_last;
        w_load    = 1'b0;
        busy      = (r_state != IDLE);
        case (r_state)
            IDLE: w_load = w_all_valid;
            SEND: begin
                out_valid = 1'b1;
                out_data  = w_rd_data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx <= '0;
        end else if (w_load) begin
            r_idx <= '0;
        end else if (r_state == SEND && r_idx != IDX_LAST) begin
            r_idx <= r_idx + IDX_W'(1);
        end
    end

    // Remembers the last streamed word so out_data holds while out_valid is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= '0;
        end else if (r_state == SEND) begin
            r_last <= w_rd_data;
        end
    end

`ifdef LAYER_SCHED_ERR_CHECK_EN
    logic w_partial;
    logic w_err_set;
    logic r_err;

    assign w_partial = (in_valid != '0) && !w_all_valid;
    assign w_err_set = (w_all_valid && r_state != IDLE) || w_partial;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_err_set) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_layer_input_scheduler.sv
// Directed self-checking bench for layer_input_scheduler with 4 neurons of 16 bits.
module tb_layer_input_scheduler;

    localparam int N  = 4;
    localparam int DW = 16;

`ifdef LAYER_SCHED_ERR_CHECK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic [N*DW-1:0]   in_data;
    logic [N-1:0]      in_valid;
    logic              next_done;
    logic [DW-1:0]     out_data;
    logic              out_valid;
    logic              busy;
    logic              err;

    int n_tests;
    int n_fail;

    layer_input_scheduler #(.numNeurons(N), .dataWidth(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .next_done (next_done),
        .out_data  (out_data),
        .out_valid (out_valid),
        .busy      (busy),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = '0;
        next_done = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic send_frame(input logic [N*DW-1:0] d);
        in_data  = d;
        in_valid = '1;
        tick();
        in_valid = '0;
    endtask

    task automatic pulse_done();
        next_done = 1'b1;
        tick();
        next_done = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_data = '0;
        in_valid = '0;
        next_done = 1'b0;
        tick();
        tick();
        n_tests++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || err !== 1'b0 || out_data !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset: out_valid=%b busy=%b err=%b out_data=%h, want 0 0 0 0000",
                     out_valid, busy, err, out_data);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic_frame();
        send_frame({16'h0004, 16'h0003, 16'h0002, 16'h0001});
        for (int i = 0; i < N; i++) begin
            n_tests++;
            if (out_valid !== 1'b1 || busy !== 1'b1 || out_data !== 16'(i + 1)) begin
                n_fail++;
                $display("FAIL basic_word%0d: out_valid=%b busy=%b out_data=%h, want 1 1 %h",
                         i, out_valid, busy, out_data, 16'(i + 1));
            end
            tick();
        end
        n_tests++;
        if (out_valid !== 1'b0 || busy !== 1'b1 || out_data !== 16'h0004) begin
            n_fail++;
            $display("FAIL basic_after: out_valid=%b busy=%b out_data=%h, want 0 1 0004",
                     out_valid, busy, out_data);
        end
    endtask

    task automatic test_completion();
        int bad;
        bad = 0;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (out_valid !== 1'b0 || busy !== 1'b1) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL wait_idle: %0d cycles with activity or busy low, want 0", bad);
        end
        pulse_done();
        n_tests++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || out_data !== 16'h0004) begin
            n_fail++;
            $display("FAIL done_busy: busy=%b out_valid=%b out_data=%h, want 0 0 0004",
                     busy, out_valid, out_data);
        end
        send_frame({16'h00DD, 16'h00CC, 16'h00BB, 16'h00AA});
        for (int i = 0; i < N; i++) begin
            n_tests++;
            if (out_valid !== 1'b1 || out_data !== 16'(16'h00AA + 16'(i * 16'h11))) begin
                n_fail++;
                $display("FAIL second_word%0d: out_valid=%b out_data=%h, want 1 %h",
                         i, out_valid, out_data, 16'(16'h00AA + 16'(i * 16'h11)));
            end
            tick();
        end
        pulse_done();
    endtask

    task automatic test_overlap();
        send_frame({16'h1004, 16'h1003, 16'h1002, 16'h1001});
        for (int i = 0; i < N; i++) begin
            n_tests++;
            if (out_valid !== 1'b1 || out_data !== 16'(16'h1001 + i)) begin
                n_fail++;
                $display("FAIL overlap_word%0d: out_valid=%b out_data=%h, want 1 %h",
                         i, out_valid, out_data, 16'(16'h1001 + i));
            end
            if (i == 1) begin
                in_data  = {16'hBEEF, 16'hBEEF, 16'hBEEF, 16'hBEEF};
                in_valid = '1;
            end else begin
                in_valid = '0;
            end
            tick();
        end
        in_valid = '0;
        n_tests++;
        if (out_valid !== 1'b0 || busy !== 1'b1 || err !== ERR_EXP) begin
            n_fail++;
            $display("FAIL overlap_end: out_valid=%b busy=%b err=%b, want 0 1 %b",
                     out_valid, busy, err, ERR_EXP);
        end
        pulse_done();
    endtask

    task automatic test_partial_valid();
        do_reset();
        in_data  = {16'h2004, 16'h2003, 16'h2002, 16'h2001};
        in_valid = 4'b0111;
        tick();
        in_valid = '0;
        tick();
        n_tests++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || err !== ERR_EXP) begin
            n_fail++;
            $display("FAIL partial: out_valid=%b busy=%b err=%b, want 0 0 %b",
                     out_valid, busy, err, ERR_EXP);
        end
    endtask

    task automatic test_reset_mid_stream();
        send_frame({16'h3004, 16'h3003, 16'h3002, 16'h3001});
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || err !== 1'b0 || out_data !== 16'h0000) begin
            n_fail++;
            $display("FAIL mid_reset: out_valid=%b busy=%b err=%b out_data=%h, want 0 0 0 0000",
                     out_valid, busy, err, out_data);
        end
        send_frame({16'h4004, 16'h4003, 16'h4002, 16'h4001});
        for (int i = 0; i < N; i++) begin
            n_tests++;
            if (out_valid !== 1'b1 || out_data !== 16'(16'h4001 + i)) begin
                n_fail++;
                $display("FAIL post_reset_word%0d: out_valid=%b out_data=%h, want 1 %h",
                         i, out_valid, out_data, 16'(16'h4001 + i));
            end
            tick();
        end
        pulse_done();
    endtask

    task automatic test_stray_done();
        int cnt;
        pulse_done();
        n_tests++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stray_idle: busy=%b out_valid=%b, want 0 0", busy, out_valid);
        end
        send_frame({16'h5004, 16'h5003, 16'h5002, 16'h5001});
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid === 1'b1) cnt++;
            next_done = (i == 1);
            tick();
        end
        next_done = 1'b0;
        n_tests++;
        if (cnt != N || busy !== 1'b1 || out_data !== 16'h5004) begin
            n_fail++;
            $display("FAIL stray_send: valid_cycles=%0d busy=%b out_data=%h, want 4 1 5004",
                     cnt, busy, out_data);
        end
        pulse_done();
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL stray_final_done: busy=%b, want 0", busy);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_basic_frame();
        test_completion();
        test_overlap();
        test_partial_valid();
        do_reset();
        test_reset_mid_stream();
        test_stray_done();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/layer_input_scheduler.md
# layer_input_scheduler

- Sits between two fully connected layers.
- Captures the parallel outputs of the previous layer's neurons in one cycle, when every neuron asserts its output valid.
- Replays the captured values as a serial input stream (one word per cycle) to every neuron of the next layer.
- Holds off the next frame until the next layer signals completion, so no neuron's read address or accumulator is disturbed mid-sum.

## Interface
Parameters:
- numNeurons, 30, neurons in the previous layer; equals numWeight of each next-layer neuron.
- dataWidth, 16, width of one neuron output / input word.

Ports:
- clk  input  1  single clock; all logic is on its rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  numNeurons*dataWidth  flattened previous-layer outputs; neuron k occupies bits [k*dataWidth +: dataWidth].
- in_valid  input  numNeurons  per-neuron output valid (one-cycle pulses).
- next_done  input  1  output valid of next-layer neuron 0; a one-cycle pulse when that layer has produced its result.
- out_data  output  dataWidth  serial word to the next layer's myinput.
- out_valid  output  1  drives the next layer's myinputValid.
- busy  output  1  high in any state other than IDLE.
- err  output  1  sticky protocol error flag (see Configuration).

## Operation
- Three states:
  - IDLE: waiting for a frame.
  - SEND: streaming the captured frame.
  - WAIT_DONE: waiting for the next layer to finish.
- IDLE -> SEND:
  - Condition: all bits of in_valid are high in the same cycle.
  - Action: latch in_data into a numNeurons x dataWidth hold register; clear the index counter to 0.
- SEND:
  - Each cycle: out_valid=1, out_data=hold[idx], idx increments.
  - When idx==numNeurons-1 is sent: -> WAIT_DONE.
  - The index counter is $clog2(numNeurons) bits wide, does not wrap mid-frame, and is cleared on entry to SEND.
- WAIT_DONE:
  - out_valid=0.
  - next_done=1 -> IDLE.
- next_done outside WAIT_DONE is ignored.
- Frame arrival (all in_valid high) while busy: the frame is dropped and the hold register is unchanged.
- Partial in_valid (non-zero but not all ones) is never a capture condition.
- Data is passed unmodified; no arithmetic or width conversion is performed.

## Timing
- Reset values: state=IDLE, out_valid=0, out_data=0, busy=0, err=0, idx=0.
- Reset asserted mid-SEND or in WAIT_DONE: all outputs return to reset values at that edge; any partial frame is abandoned.
- Latency: capture at edge T; out_valid is high for cycles T+1 .. T+numNeurons with out_data = neuron 0, 1, … in order.
- out_valid is contiguous within a frame (no bubbles).
- busy rises at T+1 and falls the cycle after the next_done edge.
- Back-to-back frames: the earliest new capture is the same cycle busy is low, i.e. one cycle after next_done is sampled.
- out_data holds its last value when out_valid=0.
- Simultaneous all-in_valid and next_done in WAIT_DONE: return to IDLE; the frame is dropped (not captured), and is flagged as an error when the check is enabled.

## Configuration
- Macro LAYER_SCHED_ERR_CHECK_EN.
- Defined: err is set, and sticky until rst, on either condition:
  - a capture condition while busy;
  - partial in_valid (0 < popcount < numNeurons).
- Undefined: err is tied to 0, and no error detection logic is synthesized.
- Scheduling behaviour is identical in both builds.

## Structure
- Shared package fnn_sched_pkg holds:
  - the state typedef (enum logic [1:0] {IDLE, SEND, WAIT_DONE});
  - a localparam-free helper function for the index width.
- Sub-module layer_hold_reg:
  - parallel-load array of numNeurons words;
  - indexed read port;
  - load enable.
- The FSM, index counter and error logic stay in layer_input_scheduler.

## Test plan
All scenarios use numNeurons=4, dataWidth=16.
- Basic frame: in_data={0x0004,0x0003,0x0002,0x0001}, in_valid=4'hF for one cycle -> out_valid high 4 cycles with out_data 0x0001,0x0002,0x0003,0x0004; busy high; no activity until next_done.
- Completion: next_done pulse 10 cycles after the stream ends -> busy low the next cycle; a second frame {…0x00AA} then streams correctly starting with 0x00AA.
- Overlap: all-valid pulse during SEND -> stream completes with the original data; err=1 (ERR_CHECK_EN defined) or err=0 (undefined).
- Partial valid: in_valid=4'b0111 in IDLE -> no capture, out_valid stays 0; err=1 with the check enabled.
- Reset mid-stream: rst high on the 2nd out_valid cycle -> next cycle out_valid=0, busy=0, err=0; a following frame streams from element 0.
- Stray done: next_done pulses in IDLE and during SEND -> no state change; the stream length is still exactly 4.
